// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
// Shared definitions for the quadrature decoder slice: Avalon register
// addresses, the ID constant, CTRL/STAT bit positions, the Gray-code state
// encodings of the {A,B} pair, and the transition classifier used by the
// decoder.
// -----------------------------------------------------------------------------
package quad_pkg;

    // Avalon word addresses
    localparam logic [2:0] ADDR_ID     = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_POS    = 3'd2;
    localparam logic [2:0] ADDR_IDX    = 3'd3;
    localparam logic [2:0] ADDR_STAT   = 3'd4;
    localparam logic [2:0] ADDR_ERRCNT = 3'd5;

    localparam logic [31:0] QUAD_ID = 32'hEA680004;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_CLR     = 1;
    localparam int CTRL_ZCLR_EN = 2;
    localparam int CTRL_FL_LSB  = 8;

    // STAT bit positions
    localparam int STAT_DIR   = 0;
    localparam int STAT_ERR   = 1;
    localparam int STAT_ZSEEN = 2;

    // {A,B} states in forward order: 00 -> 10 -> 11 -> 01 -> 00
    typedef enum logic [1:0] {
        GRAY_S0 = 2'b00,
        GRAY_S1 = 2'b10,
        GRAY_S2 = 2'b11,
        GRAY_S3 = 2'b01
    } gray_state_e;

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_FWD,
        MOVE_REV,
        MOVE_ILLEGAL
    } move_e;

    function automatic gray_state_e gray_next_fwd(input gray_state_e s);
        case (s)
            GRAY_S0: return GRAY_S1;
            GRAY_S1: return GRAY_S2;
            GRAY_S2: return GRAY_S3;
            default: return GRAY_S0;
        endcase
    endfunction

    // Classify one {A,B} transition. Both bits changing cannot be resolved
    // into a direction and is reported as illegal.
    function automatic move_e quad_move(input logic [1:0] prev_ab,
                                        input logic [1:0] cur_ab);
        if (prev_ab == cur_ab)
            return MOVE_NONE;
        else if ((prev_ab ^ cur_ab) == 2'b11)
            return MOVE_ILLEGAL;
        else if (cur_ab == gray_next_fwd(gray_state_e'(prev_ab)))
            return MOVE_FWD;
        else
            return MOVE_REV;
    endfunction

endpackage

// File: rtl/quad_pin_filter.sv
// -----------------------------------------------------------------------------
// quad_pin_filter
// Two-flop synchroniser followed by a stability filter for one encoder pin.
// The filtered output only follows the synchronised pin once it has differed
// from the current output for filt_len+1 consecutive clocks; filt_len = 0
// passes every change with the bare synchroniser latency.
//
// Ports:
//   csi_MCLK_clk      system clock
//   rsi_MRST_reset_n  asynchronous active-low reset
//   filt_len          stability length (clocks beyond the first)
//   pin               raw asynchronous pin
//   pin_f             filtered, synchronous pin
// -----------------------------------------------------------------------------
module quad_pin_filter #(
    parameter int FILT_W = 8
) (
    input  logic              csi_MCLK_clk,
    input  logic              rsi_MRST_reset_n,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              pin,
    output logic              pin_f
);

    logic              s1;
    logic              s2;
    logic [FILT_W-1:0] fc;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the two synchroniser stages into one.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            fc    <= '0;
            pin_f <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            if (s2 == pin_f) begin
                fc <= '0;
            end else if (fc == filt_len) begin
                pin_f <= s2;
                fc    <= '0;
            end else begin
                fc <= fc + FILT_W'(1);
            end
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// -----------------------------------------------------------------------------
// quadrature_decoder
// Conditions the raw A/B/Z encoder pins (synchronise + glitch filter), decodes
// A/B in 4x mode into a signed position counter, latches the position on the
// index pulse, counts illegal transitions and exposes everything on an
// Avalon-MM slave.
//
// Ports:
//   csi_MCLK_clk, rsi_MRST_reset_n   clock and async active-low reset
//   avs_ctrl_*                       Avalon-MM slave (registered readdata,
//                                    waitrequest tied low)
//   A, B, Z                          raw encoder pins
//   A_f, B_f, Z_f                    filtered pins for the downstream stage
//   step                             one-cycle pulse per counted step
//   dir                              direction of last counted step (1 = fwd)
// -----------------------------------------------------------------------------
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int FILT_W = 8,
    parameter int CNT_W  = 32,
    parameter int ERR_W  = 16
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [31:0] avs_ctrl_readdata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic        avs_ctrl_waitrequest,
    input  logic        A,
    input  logic        B,
    input  logic        Z,
    output logic        A_f,
    output logic        B_f,
    output logic        Z_f,
    output logic        step,
    output logic        dir
);

    // ---------------- control / status state ----------------
    logic              ctrl_en;
    logic              ctrl_zclr_en;
    logic [FILT_W-1:0] filt_len;
    logic [CNT_W-1:0]  pos;
    logic [CNT_W-1:0]  idx;
    logic [ERR_W-1:0]  err_cnt;
    logic              stat_err;
    logic              stat_zseen;
    logic [1:0]        prev_ab;
    logic              z_prev;

    assign avs_ctrl_waitrequest = 1'b0;

    // ---------------- pin conditioning ----------------
    quad_pin_filter #(.FILT_W(FILT_W)) u_filt_a (
        .csi_MCLK_clk     (csi_MCLK_clk),
        .rsi_MRST_reset_n (rsi_MRST_reset_n),
        .filt_len         (filt_len),
        .pin              (A),
        .pin_f            (A_f)
    );

    quad_pin_filter #(.FILT_W(FILT_W)) u_filt_b (
        .csi_MCLK_clk     (csi_MCLK_clk),
        .rsi_MRST_reset_n (rsi_MRST_reset_n),
        .filt_len         (filt_len),
        .pin              (B),
        .pin_f            (B_f)
    );

    quad_pin_filter #(.FILT_W(FILT_W)) u_filt_z (
        .csi_MCLK_clk     (csi_MCLK_clk),
        .rsi_MRST_reset_n (rsi_MRST_reset_n),
        .filt_len         (filt_len),
        .pin              (Z),
        .pin_f            (Z_f)
    );

    // ---------------- bus decode ----------------
    logic wr_ctrl;
    logic wr_stat;
    logic clr_pulse;

    assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == ADDR_CTRL);
    assign wr_stat   = avs_ctrl_write && (avs_ctrl_address == ADDR_STAT);
    assign clr_pulse = wr_ctrl && avs_ctrl_byteenable[0] && avs_ctrl_writedata[CTRL_CLR];

    // CTRL write data merged with the current value under the byte enables.
    logic              ctrl_en_nxt;
    logic              ctrl_zclr_en_nxt;
    logic [FILT_W-1:0] filt_len_nxt;

    // NOTE: every variable driven here gets a default before any branch so
    // the block stays purely combinational and no latch is inferred.
    always_comb begin
        ctrl_en_nxt      = ctrl_en;
        ctrl_zclr_en_nxt = ctrl_zclr_en;
        filt_len_nxt     = filt_len;
        if (avs_ctrl_byteenable[0]) begin
            ctrl_en_nxt      = avs_ctrl_writedata[CTRL_EN];
            ctrl_zclr_en_nxt = avs_ctrl_writedata[CTRL_ZCLR_EN];
        end
        for (int i = 0; i < FILT_W; i++) begin
            if (avs_ctrl_byteenable[2'((CTRL_FL_LSB + i) / 8)])
                filt_len_nxt[i] = avs_ctrl_writedata[5'(CTRL_FL_LSB + i)];
        end
    end

    // ---------------- decoder ----------------
    move_e move;
    logic  z_rise;
    logic  legal_step;
    logic  index_clear;
    logic  illegal;

    assign move        = quad_move(prev_ab, {A_f, B_f});
    assign z_rise      = ctrl_en && Z_f && !z_prev;
    assign legal_step  = ctrl_en && ((move == MOVE_FWD) || (move == MOVE_REV));
    assign index_clear = z_rise && ctrl_zclr_en;
    assign illegal     = (move == MOVE_ILLEGAL);

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            ctrl_en      <= 1'b0;
            ctrl_zclr_en <= 1'b0;
            filt_len     <= '0;
            pos          <= '0;
            idx          <= '0;
            err_cnt      <= '0;
            stat_err     <= 1'b0;
            stat_zseen   <= 1'b0;
            prev_ab      <= 2'b00;
            z_prev       <= 1'b0;
            step         <= 1'b0;
            dir          <= 1'b0;
        end else begin
            // Edge history runs regardless of EN so enabling never sees a
            // stale transition.
            prev_ab <= {A_f, B_f};
            z_prev  <= Z_f;
            step    <= 1'b0;

            if (wr_ctrl) begin
                ctrl_en      <= ctrl_en_nxt;
                ctrl_zclr_en <= ctrl_zclr_en_nxt;
                filt_len     <= filt_len_nxt;
            end

            // Position / index: CLR beats the index clear, which beats a step.
            if (clr_pulse) begin
                pos <= '0;
                idx <= '0;
            end else begin
                if (z_rise)
                    idx <= pos;
                if (index_clear) begin
                    pos <= '0;
                end else if (legal_step) begin
                    step <= 1'b1;
                    dir  <= (move == MOVE_FWD);
                    pos  <= (move == MOVE_FWD) ? pos + CNT_W'(1) : pos - CNT_W'(1);
                end
            end

            if (clr_pulse)
                err_cnt <= '0;
            else if (illegal && (err_cnt != '1))
                err_cnt <= err_cnt + ERR_W'(1);

            // Sticky bits: a same-cycle set wins over the W1C clear.
            if (illegal)
                stat_err <= 1'b1;
            else if (wr_stat && avs_ctrl_writedata[STAT_ERR])
                stat_err <= 1'b0;

            if (z_rise)
                stat_zseen <= 1'b1;
            else if (wr_stat && avs_ctrl_writedata[STAT_ZSEEN])
                stat_zseen <= 1'b0;
        end
    end

    // ---------------- read path ----------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (avs_ctrl_address)
            ADDR_ID: rd_mux = QUAD_ID;
            ADDR_CTRL: begin
                rd_mux[CTRL_EN]                    = ctrl_en;
                rd_mux[CTRL_ZCLR_EN]               = ctrl_zclr_en;
                rd_mux[CTRL_FL_LSB +: FILT_W]      = filt_len;
            end
            ADDR_POS:    rd_mux = 32'(signed'(pos));
            ADDR_IDX:    rd_mux = 32'(signed'(idx));
            ADDR_STAT: begin
                rd_mux[STAT_DIR]   = dir;
                rd_mux[STAT_ERR]   = stat_err;
                rd_mux[STAT_ZSEEN] = stat_zseen;
            end
            ADDR_ERRCNT: rd_mux = 32'(err_cnt);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n)
            avs_ctrl_readdata <= '0;
        else if (avs_ctrl_read)
            avs_ctrl_readdata <= rd_mux;
    end

    // Write-data bits and byte enables that no register field consumes.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{avs_ctrl_writedata, avs_ctrl_byteenable};

endmodule

// File: tb/tb_quadrature_decoder.sv
// -----------------------------------------------------------------------------
// tb_quadrature_decoder
// Directed self-checking bench for quadrature_decoder.
// -----------------------------------------------------------------------------
module tb_quadrature_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  byteenable;
    logic [2:0]  address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic        A, B, Z;
    logic        A_f, B_f, Z_f;
    logic        step;
    logic        dir;

    int checks   = 0;
    int failures = 0;

    // bench-side model of the pin pair
    logic [1:0] ab;
    int         step_count = 0;
    int         af_toggles = 0;
    logic       af_last    = 1'b0;

    quadrature_decoder dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset_n     (rst_n),
        .avs_ctrl_writedata   (writedata),
        .avs_ctrl_readdata    (readdata),
        .avs_ctrl_byteenable  (byteenable),
        .avs_ctrl_address     (address),
        .avs_ctrl_write       (write),
        .avs_ctrl_read        (read),
        .avs_ctrl_waitrequest (waitrequest),
        .A                    (A),
        .B                    (B),
        .Z                    (Z),
        .A_f                  (A_f),
        .B_f                  (B_f),
        .Z_f                  (Z_f),
        .step                 (step),
        .dir                  (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step === 1'b1) step_count++;
        if (A_f !== af_last) af_toggles++;
        af_last = A_f;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus / pin helpers ----------------
    task automatic avs_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        @(negedge clk);
        write = 1'b0; byteenable = 4'h0;
    endtask

    task automatic avs_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        d = readdata; read = 1'b0;
    endtask

    function automatic logic [1:0] next_ab(input logic [1:0] s, input bit fwd);
        logic [1:0] n;
        if (fwd)
            case (s) 2'b00: n = 2'b10; 2'b10: n = 2'b11; 2'b11: n = 2'b01; default: n = 2'b00; endcase
        else
            case (s) 2'b00: n = 2'b01; 2'b01: n = 2'b11; 2'b11: n = 2'b10; default: n = 2'b00; endcase
        return n;
    endfunction

    // One quadrature edge, then hold for hold_cycles clocks. Reports how many
    // step pulses were seen and how many arrived at other than 8 clocks.
    task automatic quad_move(input bit fwd, input int hold_cycles,
                             output int steps, output int late);
        steps = 0; late = 0;
        @(negedge clk);
        ab = next_ab(ab, fwd);
        {A, B} = ab;
        for (int k = 1; k <= hold_cycles; k++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                steps++;
                if (k != 8) late++;
            end
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_tab [6];
        exp_tab = '{32'hEA680004, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        checks++;
        if (readdata !== 32'h0) begin
            $display("FAIL reset_readdata: got %h want 00000000", readdata); failures++;
        end
        checks++;
        if ({A_f, B_f, Z_f, step, dir} !== 5'b0) begin
            $display("FAIL reset_outputs: got %b want 00000", {A_f, B_f, Z_f, step, dir}); failures++;
        end
        for (int a = 0; a < 6; a++) begin
            avs_read(3'(a), d);
            checks++;
            if (d !== exp_tab[a]) begin
                $display("FAIL reset_reg%0d: got %h want %h", a, d, exp_tab[a]); failures++;
            end
        end
        checks++;
        if (waitrequest !== 1'b0) begin
            $display("FAIL waitrequest: got %b want 0", waitrequest); failures++;
        end
    endtask

    task automatic test_forward();
        logic [31:0] d;
        int s, l, tot_s, tot_l, start;
        tot_s = 0; tot_l = 0;
        avs_write(3'd1, 32'h0000_0401, 4'hF);   // FL = 4, EN = 1
        start = step_count;
        for (int i = 0; i < 40; i++) begin
            quad_move(1'b1, 20, s, l);
            tot_s += s; tot_l += l;
        end
        checks++;
        if (tot_s !== 40 || (step_count - start) !== 40) begin
            $display("FAIL fwd_steps: got %0d want 40", tot_s); failures++;
        end
        checks++;
        if (tot_l !== 0) begin
            $display("FAIL fwd_latency: %0d steps not 8 clocks after edge, want 0", tot_l); failures++;
        end
        avs_read(3'd2, d);
        checks++;
        if (d !== 32'd40) begin
            $display("FAIL fwd_pos: got %0d want 40", d); failures++;
        end
        checks++;
        if (dir !== 1'b1) begin
            $display("FAIL fwd_dir: got %b want 1", dir); failures++;
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        int t0;
        t0 = af_toggles;
        @(negedge clk); A = 1'b1;
        wait_clk(3);    A = 1'b0;
        wait_clk(20);
        checks++;
        if ((af_toggles - t0) !== 0) begin
            $display("FAIL glitch3_af: toggles %0d want 0", af_toggles - t0); failures++;
        end
        avs_read(3'd2, d);
        checks++;
        if (d !== 32'd40) begin
            $display("FAIL glitch3_pos: got %0d want 40", d); failures++;
        end
        t0 = af_toggles;
        @(negedge clk); A = 1'b1;
        wait_clk(5);    A = 1'b0;
        wait_clk(20);
        checks++;
        if ((af_toggles - t0) !== 2) begin
            $display("FAIL glitch5_af: toggles %0d want 2", af_toggles - t0); failures++;
        end
        avs_read(3'd2, d);
        checks++;
        if (d !== 32'd40) begin
            $display("FAIL glitch5_pos: got %0d want 40", d); failures++;
        end
    endtask

    task automatic test_index();
        logic [31:0] d;
        int s, l;
        avs_write(3'd1, 32'h0000_0407, 4'hF);   // CLR, EN, ZCLR_EN, FL = 4
        for (int i = 0; i < 17; i++) quad_move(1'b1, 12, s, l);
        avs_read(3'd2, d);
        checks++;
        if (d !== 32'd17) begin
            $display("FAIL idx_prepos: got %0d want 17", d); failures++;
        end
        @(negedge clk); Z = 1'b1;
        wait_clk(12);   Z = 1'b0;
        wait_clk(12);
        avs_read(3'd3, d);
        checks++;
        if (d !== 32'd17) begin
            $display("FAIL idx_latch: got %0d want 17", d); failures++;
        end
        avs_read(3'd2, d);
        checks++;
        if (d !== 32'd0) begin
            $display("FAIL idx_posclr: got %0d want 0", d); failures++;
        end
        avs_read(3'd4, d);
        checks++;
        if (d !== 32'h5) begin
            $display("FAIL idx_stat: got %h want 00000005", d); failures++;
        end
        avs_write(3'd4, 32'h4, 4'hF);
        avs_read(3'd4, d);
        checks++;
        if (d !== 32'h1) begin
            $display("FAIL idx_w1c: got %h want 00000001", d); failures++;
        end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        avs_write(3'd1, 32'h0000_0001, 4'hF);   // EN, FL = 0
        @(negedge clk);
        ab = ~ab;                               // 10 -> 01: both bits flip
        {A, B} = ab;
        wait_clk(10);
        avs_read(3'd4, d);
        checks++;
        if (d !== 32'h3) begin
            $display("FAIL ill_stat: got %h want 00000003", d); failures++;
        end
        avs_read(3'd5, d);
        checks++;
        if (d !== 32'd1) begin
            $display("FAIL ill_errcnt: got %0d want 1", d); failures++;
        end
        avs_read(3'd2, d);
        checks++;
        if (d !== 32'd0) begin
            $display("FAIL ill_pos: got %0d want 0", d); failures++;
        end
        avs_write(3'd1, 32'h0000_0003, 4'hF);   // CLR
        avs_read(3'd5, d);
        checks++;
        if (d !== 32'd0) begin
            $display("FAIL clr_errcnt: got %0d want 0", d); failures++;
        end
        avs_read(3'd4, d);
        checks++;
        if (d !== 32'h3) begin
            $display("FAIL clr_err_sticky: got %h want 00000003", d); failures++;
        end
        avs_read(3'd1, d);
        checks++;
        if (d !== 32'h1) begin
            $display("FAIL clr_selfclear: got %h want 00000001", d); failures++;
        end
    endtask

    task automatic test_wrap_and_disable();
        logic [31:0] d;
        int s, l, start;
        quad_move(1'b0, 12, s, l);
        avs_read(3'd2, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            $display("FAIL wrap_pos: got %h want ffffffff", d); failures++;
        end
        checks++;
        if (dir !== 1'b0) begin
            $display("FAIL wrap_dir: got %b want 0", dir); failures++;
        end
        avs_write(3'd1, 32'h0, 4'hF);           // EN = 0
        start = step_count;
        for (int i = 0; i < 5; i++) quad_move(1'b1, 12, s, l);
        checks++;
        if ((step_count - start) !== 0) begin
            $display("FAIL dis_steps: got %0d want 0", step_count - start); failures++;
        end
        avs_read(3'd2, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            $display("FAIL dis_pos: got %h want ffffffff", d); failures++;
        end
    endtask

    task automatic test_byteenable();
        logic [31:0] d;
        avs_write(3'd1, 32'h0000_0305, 4'b0001);
        avs_read(3'd1, d);
        checks++;
        if (d !== 32'h5) begin
            $display("FAIL be_byte0: got %h want 00000005", d); failures++;
        end
        avs_write(3'd1, 32'h0000_0700, 4'b0010);
        avs_read(3'd1, d);
        checks++;
        if (d !== 32'h705) begin
            $display("FAIL be_byte1: got %h want 00000705", d); failures++;
        end
        avs_read(3'd6, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL unmapped: got %h want 00000000", d); failures++;
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] d;
        logic [31:0] exp_tab [5];
        exp_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};   // CTRL..ERRCNT
        @(negedge clk); rst_n = 1'b0;
        wait_clk(2);
        checks++;
        if ({A_f, B_f, Z_f, step, readdata} !== 36'h0) begin
            $display("FAIL midrst_outputs: got %b %h want 0", {A_f, B_f, Z_f, step}, readdata); failures++;
        end
        rst_n = 1'b1;
        wait_clk(10);
        for (int a = 1; a < 6; a++) begin
            avs_read(3'(a), d);
            checks++;
            if (d !== exp_tab[a-1]) begin
                $display("FAIL midrst_reg%0d: got %h want %h", a, d, exp_tab[a-1]); failures++;
            end
        end
        checks++;
        if ({A_f, B_f} !== ab) begin
            $display("FAIL midrst_pins: got %b want %b", {A_f, B_f}, ab); failures++;
        end
    endtask

    initial begin
        rst_n = 1'b0; writedata = '0; byteenable = '0; address = '0;
        write = 1'b0; read = 1'b0; A = 1'b0; B = 1'b0; Z = 1'b0; ab = 2'b00;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        test_reset();
        test_forward();
        test_glitch();
        test_index();
        test_illegal();
        test_wrap_and_disable();
        test_byteenable();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
Upstream conditioning stage for the quadrature position-encoder sensor. The block does the following:
- Synchronises and glitch-filters the raw A/B/Z pins.
- Performs 4x quadrature decoding into a signed position counter, with index (Z) capture and illegal-transition detection.
- Exposes the filtered A_f/B_f/Z_f pins to the downstream position-encoder counter.
- Exposes all state through a Qsys Avalon-MM slave.

Parameters:
FILT_W, 8, width of the programmable filter length field and of the per-pin stability counters.
CNT_W, 32, width of the signed position and index-latch registers; must be 32 or less.
ERR_W, 16, width of the saturating illegal-transition counter.

Ports:
csi_MCLK_clk  in  1  system clock; single clock domain.
rsi_MRST_reset_n  in  1  reset; asynchronous assertion, active-low.
avs_ctrl_writedata  in  32  Avalon write data.
avs_ctrl_readdata  out  32  Avalon read data, registered.
avs_ctrl_byteenable  in  4  byte enables; honoured on the CTRL register only.
avs_ctrl_address  in  3  word address.
avs_ctrl_write  in  1  write strobe.
avs_ctrl_read  in  1  read strobe.
avs_ctrl_waitrequest  out  1  tied 0.
A, B, Z  in  1 each  raw asynchronous encoder pins.
A_f, B_f, Z_f  out  1 each  filtered pins for the downstream stage.
step  out  1  one-cycle pulse on every legal count.
dir  out  1  direction of the last legal step (1 = forward).

Behaviour:
Reset values:
- All registers, outputs, counters, sync flops and the previous-state register are 0.
- Filter length is 0.
- Enable is 0.

Register map (readdata is valid 1 cycle after the address is presented; unmapped addresses read 0):
- 0 ID: reads 32'hEA680004.
- 1 CTRL: bit0 EN; bit1 CLR (write-1, self-clearing, reads 0); bit2 ZCLR_EN; bits[8+FILT_W-1:8] FILT_LEN (FL).
- 2 POS: position, sign-extended to 32 bits; read-only.
- 3 IDX: position latched at the index; read-only.
- 4 STAT: bit0 dir; bit1 ERR (sticky); bit2 ZSEEN (sticky). Both sticky bits are cleared by writing 1 (W1C).
- 5 ERRCNT: saturating at all-ones; cleared by CLR.

Synchroniser and filter (per pin):
- Two-flop synchroniser produces s2.
- Filter counter fc and filtered output f.
- If s2 == f: fc <= 0.
- Else if fc == FL: f <= s2, fc <= 0.
- Else: fc <= fc + 1.
- A pin edge reaches f exactly 3+FL clocks after the first sampling edge.
- A glitch shorter than FL+1 clocks at s2 never reaches f.
- FL = 0 passes everything with 3 cycles of latency.

Decoder:
- prev <= {A_f, B_f} every cycle, independent of EN.
- Forward sequence (+1): 00->10->11->01->00. Reverse (-1): the opposite order.
- No change: no action.
- Both bits change: illegal. No count, ERR set, ERRCNT incremented (saturating), step not pulsed.
- When EN = 0, legal transitions update only prev; no step, no count.
- POS updates, and step pulses, 1 cycle after the f change, i.e. 4+FL clocks after the pin edge.
- POS wraps in two's complement: max + 1 -> min, 0 - 1 -> all-ones.

Index (rising edge of Z_f while EN = 1):
- IDX <= POS value before this cycle's update; ZSEEN set.
- If ZCLR_EN = 1, POS <= 0 and any same-cycle step is discarded.

Priority:
- Same cycle: CLR write > index clear > step. CLR zeroes POS, IDX and ERRCNT.
- Same cycle: a sticky-bit set wins over a W1C clear.

Reset mid-operation: all state returns to reset values immediately. The first post-reset filtered value is taken against f = 0 and may produce one decode transition; if it is illegal it is counted as an error.

Decomposition:
- Shared package quad_pkg holds: register address constants (ADDR_ID through ADDR_ERRCNT), ID value 32'hEA680004, CTRL/STAT bit indices, and the 2-bit Gray state encodings.
- One sub-module, quad_pin_filter (synchroniser plus stability filter, parameter FILT_W), is instantiated three times.

Test Plan:
- Reset, then read addresses 0..5 -> 32'hEA680004, then 0,0,0,0,0; A_f/B_f/Z_f = 0; waitrequest always 0.
- FL = 4, EN = 1; 10 forward quadrature cycles with 20-clock phases -> POS = 40, dir = 1, 40 step pulses; each step occurs 8 clocks after its pin edge.
- FL = 4; 3-clock pulse on A -> A_f unchanged, POS unchanged; 5-clock pulse -> A_f toggles twice, POS returns to its start value.
- ZCLR_EN = 1, POS = 17, Z pulse -> IDX = 17, POS = 0, ZSEEN = 1; write 4 to STAT -> ZSEEN = 0.
- Force A and B to change in the same cycle (FL = 0) -> ERR = 1, ERRCNT = 1, POS unchanged; CLR -> ERRCNT = 0, ERR still 1.
- From POS = 0, one reverse step -> POS reads 32'hFFFFFFFF; with EN = 0, 5 steps -> POS unchanged, no step pulses.
